// File: rtl/nios_led_onchip_ram_pipe.sv
// Single-port on-chip RAM with an Avalon-MM pipelined slave port, post-reset clear and read pipeline.
// Define ONCHIP_RAM_PARITY_EN to store and check one even-parity bit per byte.
module nios_led_onchip_ram_pipe #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reset_req,
  input  logic                  clken,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic [DATA_W-1:0]     writedata,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest,
  output logic                  parity_err,
  output logic                  dbg_state
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit CLR   = (CLEAR_ON_RESET != 0);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              en;
  logic              clr_we;
  logic              accept, wr_acc, rd_acc;
  logic              rd_perr;

  // Handshake: a request is taken on a clock edge when chipselect & (read|write) & !waitrequest;
  // the master holds the request while waitrequest=1. Read data is valid only with readdatavalid=1.
  assign en     = clken & ~reset_req;
  assign accept = chipselect & (read | write) & ~waitrequest;
  assign wr_acc = accept & write;
  assign rd_acc = accept & read & ~write;
  assign dbg_state = state;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && en) begin
      if (!CLR || clr_cnt == {ADDR_W{1'b1}}) state_nxt = ST_RUN;
    end
  end

  // FSM: outputs
  always_comb begin
    waitrequest = (state == ST_INIT) | ~en;
    clr_we      = (state == ST_INIT) & en & CLR;
  end

  // Clear counter pauses with the enable and restarts from 0 on every reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         clr_cnt <= '0;
    else if (state == ST_INIT && en)   clr_cnt <= clr_cnt + ADDR_W'(1);
  end

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (byteenable[b]) mem[address][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

`ifdef ONCHIP_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];

  function automatic logic [NB-1:0] calc_par(input logic [DATA_W-1:0] w);
    logic [NB-1:0] p;
    for (int b = 0; b < NB; b++) p[b] = ^w[8*b +: 8];
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (byteenable[b]) par_mem[address][b] <= ^writedata[8*b +: 8];
      end
    end
  end

  assign rd_perr = |(par_mem[address] ^ calc_par(mem[address]));
`else
  assign rd_perr = 1'b0;
`endif

  // Stage 1: memory read register; the whole pipeline freezes while stalled.
  logic              v1, p1;
  logic [DATA_W-1:0] d1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      d1 <= '0;
      p1 <= 1'b0;
    end else if (en) begin
      v1 <= rd_acc;
      if (rd_acc) begin
        d1 <= mem[address];
        p1 <= rd_perr;
      end
    end
  end

  logic              v_out, p_out;
  logic [DATA_W-1:0] d_out;

  generate
    if (READ_LATENCY >= 2) begin : g_lat2
      logic              v2, p2;
      logic [DATA_W-1:0] d2;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v2 <= 1'b0;
          d2 <= '0;
          p2 <= 1'b0;
        end else if (en) begin
          v2 <= v1;
          d2 <= d1;
          p2 <= p1;
        end
      end
      assign v_out = v2;
      assign d_out = d2;
      assign p_out = p2;
    end else begin : g_lat1
      assign v_out = v1;
      assign d_out = d1;
      assign p_out = p1;
    end
  endgenerate

  // A valid beat is presented only in an enabled cycle, so a stall delays it instead of repeating it.
  logic [DATA_W-1:0] rd_hold;

  assign readdatavalid = v_out & en;
  assign readdata      = readdatavalid ? d_out : rd_hold;
  assign parity_err    = readdatavalid & p_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              rd_hold <= '0;
    else if (readdatavalid) rd_hold <= d_out;
  end

endmodule
